// File: rtl/alu_pkg.sv
// Shared definitions for the nibble-serial ALU and its combinational slice.
// Holds the 3-bit op codes (matching ALU op codes 0-7), the flag bit
// positions within {Z,N,H,C} and the sequencer state type.
package alu_pkg;

  typedef enum logic [2:0] {
    OP_ADD = 3'b000,
    OP_ADC = 3'b001,
    OP_SUB = 3'b010,
    OP_SBC = 3'b011,
    OP_AND = 3'b100,
    OP_XOR = 3'b101,
    OP_OR  = 3'b110,
    OP_CP  = 3'b111
  } alu_op_e;

  localparam int unsigned F_Z = 3;
  localparam int unsigned F_N = 2;
  localparam int unsigned F_H = 1;
  localparam int unsigned F_C = 0;

  typedef enum logic {
    ST_IDLE,
    ST_RUN
  } alu_state_e;

  // Ops that propagate a carry/borrow chain across nibbles.
  function automatic logic op_is_arith(alu_op_e op);
    return (op == OP_ADD) || (op == OP_ADC) || (op == OP_SUB) ||
           (op == OP_SBC) || (op == OP_CP);
  endfunction

  // Ops that subtract and therefore set N.
  function automatic logic op_is_sub(alu_op_e op);
    return (op == OP_SUB) || (op == OP_SBC) || (op == OP_CP);
  endfunction

  // Ops whose initial carry-in comes from the incoming C flag.
  function automatic logic op_uses_cin(alu_op_e op);
    return (op == OP_ADC) || (op == OP_SBC);
  endfunction

endpackage

// File: rtl/alu_nibble.sv
// Combinational 4-bit ALU slice.
// Ports:
//   op    - operation code (alu_op_e)
//   a_nib - first operand nibble
//   b_nib - second operand nibble
//   cin   - carry (add) or borrow (subtract) in; ignored by logic ops
//   r_nib - result nibble
//   cout  - carry/borrow out; 0 for logic ops
module alu_nibble
  import alu_pkg::*;
(
  input  alu_op_e    op,
  input  logic [3:0] a_nib,
  input  logic [3:0] b_nib,
  input  logic       cin,
  output logic [3:0] r_nib,
  output logic       cout
);

  logic [4:0] wide;

  always_comb begin
    wide  = '0;
    r_nib = '0;
    cout  = 1'b0;
    unique case (op)
      OP_ADD, OP_ADC: begin
        wide  = {1'b0, a_nib} + {1'b0, b_nib} + {4'b0000, cin};
        r_nib = wide[3:0];
        cout  = wide[4];
      end
      OP_SUB, OP_SBC, OP_CP: begin
        // Five-bit wrap: bit 4 is set exactly when the nibble underflows.
        wide  = {1'b0, a_nib} - {1'b0, b_nib} - {4'b0000, cin};
        r_nib = wide[3:0];
        cout  = wide[4];
      end
      OP_AND: r_nib = a_nib & b_nib;
      OP_XOR: r_nib = a_nib ^ b_nib;
      OP_OR:  r_nib = a_nib | b_nib;
      default: r_nib = '0;
    endcase
  end

endmodule

// File: rtl/alu_serial.sv
// Nibble-serial ALU: processes WIDTH-bit operands four bits per clock,
// LSB nibble first, behind a start/done handshake.
// Ports:
//   clk, rst_n - clock and synchronous active-low reset
//   start      - request, accepted when start & ready
//   op         - operation (ADD ADC SUB SBC AND XOR OR CP)
//   a, b       - operands, sampled only at the accepting edge
//   flags_in   - {Z,N,H,C}; C feeds ADC/SBC, Z is passed through on keep_z
//   keep_z     - output Z taken from flags_in Z instead of the result
//   ready      - idle, a start may be accepted
//   done       - one-cycle pulse, result/flags_out valid from this cycle
//   result     - registered result, held until the next completion
//   flags_out  - registered {Z,N,H,C}, held like result
module alu_serial
  import alu_pkg::*;
#(
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [2:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [3:0]       flags_in,
  input  logic             keep_z,
  output logic             ready,
  output logic             done,
  output logic [WIDTH-1:0] result,
  output logic [3:0]       flags_out
);

  localparam int unsigned N  = WIDTH / 4;
  localparam int unsigned KW = (N > 1) ? $clog2(N) : 1;

  if (((WIDTH % 4) != 0) || (WIDTH < 8)) begin : g_width_check
    $error("alu_serial: WIDTH must be a multiple of 4 and at least 8");
  end

  alu_state_e       state_q, state_d;
  logic [KW-1:0]    k_q, k_d;
  alu_op_e          op_q, op_d;
  logic [WIDTH-1:0] a_sh_q, a_sh_d;
  logic [WIDTH-1:0] b_sh_q, b_sh_d;
  logic [WIDTH-1:0] res_sh_q, res_sh_d;
  logic             carry_q, carry_d;
  logic             h_q, h_d;
  logic             nz_q, nz_d;
  logic             fz_q, fz_d;
  logic             kz_q, kz_d;
  logic [WIDTH-1:0] result_q, result_d;
  logic [3:0]       flags_q, flags_d;
  logic             done_q, done_d;

  logic [3:0]       r_nib;
  logic             cout;
  logic             last;
  logic             accept;
  logic             unused_flag_bits;

  assign unused_flag_bits = ^{flags_in[F_N], flags_in[F_H]};

  assign last   = (state_q == ST_RUN) && (k_q == KW'(N - 1));
  assign accept = (state_q == ST_IDLE) && start;

  alu_nibble u_nibble (
    .op    (op_q),
    .a_nib (a_sh_q[3:0]),
    .b_nib (b_sh_q[3:0]),
    .cin   (carry_q),
    .r_nib (r_nib),
    .cout  (cout)
  );

  // State register plus datapath registers.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q  <= ST_IDLE;
      k_q      <= '0;
      op_q     <= OP_ADD;
      a_sh_q   <= '0;
      b_sh_q   <= '0;
      res_sh_q <= '0;
      carry_q  <= 1'b0;
      h_q      <= 1'b0;
      nz_q     <= 1'b0;
      fz_q     <= 1'b0;
      kz_q     <= 1'b0;
      result_q <= '0;
      flags_q  <= '0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      k_q      <= k_d;
      op_q     <= op_d;
      a_sh_q   <= a_sh_d;
      b_sh_q   <= b_sh_d;
      res_sh_q <= res_sh_d;
      carry_q  <= carry_d;
      h_q      <= h_d;
      nz_q     <= nz_d;
      fz_q     <= fz_d;
      kz_q     <= kz_d;
      result_q <= result_d;
      flags_q  <= flags_d;
      done_q   <= done_d;
    end
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_IDLE: if (start) state_d = ST_RUN;
      ST_RUN:  if (last)  state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // Datapath next values.
  always_comb begin
    k_d      = k_q;
    op_d     = op_q;
    a_sh_d   = a_sh_q;
    b_sh_d   = b_sh_q;
    res_sh_d = res_sh_q;
    carry_d  = carry_q;
    h_d      = h_q;
    nz_d     = nz_q;
    fz_d     = fz_q;
    kz_d     = kz_q;
    result_d = result_q;
    flags_d  = flags_q;
    done_d   = 1'b0;

    if (accept) begin
      op_d    = alu_op_e'(op);
      a_sh_d  = a;
      b_sh_d  = b;
      fz_d    = flags_in[F_Z];
      kz_d    = keep_z;
      k_d     = '0;
      carry_d = op_uses_cin(alu_op_e'(op)) ? flags_in[F_C] : 1'b0;
      h_d     = 1'b0;
      nz_d    = 1'b0;
    end else if (state_q == ST_RUN) begin
      // a rotates rather than shifts so that after N steps it holds the
      // captured operand again, which is what CP returns as its result.
      a_sh_d   = {a_sh_q[3:0], a_sh_q[WIDTH-1:4]};
      b_sh_d   = {4'b0000, b_sh_q[WIDTH-1:4]};
      res_sh_d = {r_nib, res_sh_q[WIDTH-1:4]};
      carry_d  = cout;
      nz_d     = nz_q | (r_nib != 4'b0000);
      if (k_q == KW'(N - 2)) h_d = cout;
      k_d = k_q + KW'(1);

      if (last) begin
        k_d      = '0;
        done_d   = 1'b1;
        result_d = (op_q == OP_CP) ? a_sh_d : res_sh_d;
        flags_d[F_Z] = kz_q ? fz_q : ~nz_d;
        flags_d[F_N] = op_is_sub(op_q);
        flags_d[F_H] = op_is_arith(op_q) ? h_q : (op_q == OP_AND);
        flags_d[F_C] = op_is_arith(op_q) ? cout : 1'b0;
      end
    end
  end

  // Outputs.
  always_comb begin
    ready     = (state_q == ST_IDLE);
    done      = done_q;
    result    = result_q;
    flags_out = flags_q;
  end

endmodule

// File: tb/tb_alu_serial.sv
// Scoreboard bench for alu_serial at WIDTH=8 and WIDTH=16.
module tb_alu_serial;

  localparam logic [2:0] ADD = 3'b000, ADC = 3'b001, SUB = 3'b010, SBC = 3'b011;
  localparam logic [2:0] AND_ = 3'b100, XOR_ = 3'b101, OR_ = 3'b110, CP = 3'b111;

  typedef struct {
    logic [15:0] res;
    logic [3:0]  flags;
    int unsigned acc;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n;
  int unsigned cyc = 0;
  int errors = 0;
  int checks = 0;

  logic        start8, kz8, ready8, done8;
  logic [2:0]  op8;
  logic [7:0]  a8, b8, res8;
  logic [3:0]  fin8, fl8;

  logic        start16, kz16, ready16, done16;
  logic [2:0]  op16;
  logic [15:0] a16, b16, res16;
  logic [3:0]  fin16, fl16;

  exp_t q8[$];
  exp_t q16[$];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  alu_serial #(.WIDTH(8)) u_dut8 (
    .clk(clk), .rst_n(rst_n), .start(start8), .op(op8), .a(a8), .b(b8),
    .flags_in(fin8), .keep_z(kz8), .ready(ready8), .done(done8),
    .result(res8), .flags_out(fl8)
  );

  alu_serial #(.WIDTH(16)) u_dut16 (
    .clk(clk), .rst_n(rst_n), .start(start16), .op(op16), .a(a16), .b(b16),
    .flags_in(fin16), .keep_z(kz16), .ready(ready16), .done(done16),
    .result(res16), .flags_out(fl16)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Monitors: pop an expectation whenever a done pulse appears.
  always @(posedge clk) begin
    #1;
    if (done8) begin
      if (q8.size() == 0) chk("done8_unexpected", 32'd1, 32'd0);
      else begin
        exp_t e;
        e = q8.pop_front();
        chk("result8", 32'(res8), 32'(e.res[7:0]));
        chk("flags8", 32'(fl8), 32'(e.flags));
        chk("latency8", cyc - e.acc, 32'd2);
      end
    end
  end

  always @(posedge clk) begin
    #1;
    if (done16) begin
      if (q16.size() == 0) chk("done16_unexpected", 32'd1, 32'd0);
      else begin
        exp_t e;
        e = q16.pop_front();
        chk("result16", 32'(res16), 32'(e.res));
        chk("flags16", 32'(fl16), 32'(e.flags));
        chk("latency16", cyc - e.acc, 32'd4);
      end
    end
  end

  task automatic issue8(input logic [2:0] o, input logic [7:0] av, input logic [7:0] bv,
                        input logic [3:0] fin, input logic kz,
                        input logic [7:0] er, input logic [3:0] ef);
    int unsigned n = 0;
    @(negedge clk);
    while (!ready8 && n < 20) begin @(negedge clk); n++; end
    if (!ready8) chk("ready8_timeout", 32'd0, 32'd1);
    start8 = 1'b1; op8 = o; a8 = av; b8 = bv; fin8 = fin; kz8 = kz;
    q8.push_back('{res: {8'h00, er}, flags: ef, acc: cyc + 1});
    @(negedge clk);
    start8 = 1'b0; a8 = 8'hA5; b8 = 8'h5A; fin8 = 4'hF; kz8 = 1'b0;
  endtask

  task automatic issue16(input logic [2:0] o, input logic [15:0] av, input logic [15:0] bv,
                         input logic [3:0] fin, input logic kz,
                         input logic [15:0] er, input logic [3:0] ef);
    int unsigned n = 0;
    @(negedge clk);
    while (!ready16 && n < 20) begin @(negedge clk); n++; end
    if (!ready16) chk("ready16_timeout", 32'd0, 32'd1);
    start16 = 1'b1; op16 = o; a16 = av; b16 = bv; fin16 = fin; kz16 = kz;
    q16.push_back('{res: er, flags: ef, acc: cyc + 1});
    @(negedge clk);
    start16 = 1'b0; a16 = 16'hA5A5; b16 = 16'h5A5A; fin16 = 4'hF; kz16 = 1'b0;
  endtask

  task automatic drain();
    int unsigned n = 0;
    while ((q8.size() != 0 || q16.size() != 0) && n < 100) begin
      @(negedge clk);
      n++;
    end
    chk("drain_pending", 32'(q8.size() + q16.size()), 32'd0);
  endtask

  initial begin
    int unsigned t_acc;
    rst_n = 1'b0;
    start8 = 1'b0; op8 = ADD; a8 = '0; b8 = '0; fin8 = '0; kz8 = 1'b0;
    start16 = 1'b0; op16 = ADD; a16 = '0; b16 = '0; fin16 = '0; kz16 = 1'b0;
    repeat (2) @(negedge clk);
    chk("rst_ready8", 32'(ready8), 32'd1);
    chk("rst_done8", 32'(done8), 32'd0);
    chk("rst_result8", 32'(res8), 32'd0);
    chk("rst_flags8", 32'(fl8), 32'd0);
    chk("rst_ready16", 32'(ready16), 32'd1);
    chk("rst_result16", 32'(res16), 32'd0);
    chk("rst_flags16", 32'(fl16), 32'd0);
    rst_n = 1'b1;

    // WIDTH=8 vectors
    issue8(ADD,  8'h3A, 8'hC6, 4'b0000, 1'b0, 8'h00, 4'b1011);
    issue8(SUB,  8'h3E, 8'h0F, 4'b0000, 1'b0, 8'h2F, 4'b0110);
    issue8(SBC,  8'h10, 8'h0F, 4'b0001, 1'b0, 8'h00, 4'b1110);
    issue8(CP,   8'h90, 8'h90, 4'b0000, 1'b0, 8'h90, 4'b1100);
    issue8(AND_, 8'hF0, 8'h0F, 4'b0000, 1'b0, 8'h00, 4'b1010);
    issue8(ADC,  8'hFF, 8'h00, 4'b0001, 1'b0, 8'h00, 4'b1011);
    issue8(XOR_, 8'hFF, 8'h0F, 4'b0000, 1'b0, 8'hF0, 4'b0000);
    issue8(OR_,  8'h00, 8'h00, 4'b0001, 1'b0, 8'h00, 4'b1000);

    // WIDTH=16 vectors
    issue16(ADD, 16'h0FFF, 16'h0001, 4'b1000, 1'b1, 16'h1000, 4'b1010);
    issue16(ADD, 16'hFFFF, 16'h0001, 4'b0000, 1'b0, 16'h0000, 4'b1011);
    issue16(CP,  16'h1234, 16'h1235, 4'b0000, 1'b0, 16'h1234, 4'b0111);
    drain();

    // start held high through an op; operands change mid-run
    @(negedge clk);
    start16 = 1'b1; op16 = ADD; a16 = 16'h1234; b16 = 16'h1111; fin16 = '0; kz16 = 1'b0;
    t_acc = cyc + 1;
    q16.push_back('{res: 16'h2345, flags: 4'b0000, acc: t_acc});
    @(negedge clk);
    @(negedge clk);
    chk("ready16_low_in_run", 32'(ready16), 32'd0);
    a16 = 16'h7FFF; b16 = 16'h0001;
    q16.push_back('{res: 16'h8000, flags: 4'b0010, acc: t_acc + 5});
    repeat (3) @(negedge clk);
    chk("ready16_in_done_cycle", 32'(ready16), 32'd1);
    @(negedge clk);
    start16 = 1'b0;
    drain();

    // reset mid-run discards the op
    @(negedge clk);
    start16 = 1'b1; op16 = ADD; a16 = 16'hAAAA; b16 = 16'h5555;
    @(negedge clk);
    start16 = 1'b0;
    @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    chk("midrst_ready16", 32'(ready16), 32'd1);
    chk("midrst_done16", 32'(done16), 32'd0);
    chk("midrst_result16", 32'(res16), 32'd0);
    chk("midrst_flags16", 32'(fl16), 32'd0);
    chk("midrst_flags8", 32'(fl8), 32'd0);
    repeat (6) @(negedge clk);

    issue16(ADD, 16'h1234, 16'h1111, 4'b0000, 1'b0, 16'h2345, 4'b0000);
    issue8(ADD, 8'h08, 8'h08, 4'b0000, 1'b0, 8'h10, 4'b0010);
    drain();
    repeat (3) @(negedge clk);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
